// File: rtl/data_register.sv
// rtl/data_register.sv - masked-write storage field with clear, change pulse and parity
module data_register #(
    parameter int unsigned      WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_en,
    input  logic [WIDTH-1:0] w_mask,
    input  logic             clr,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             changed,
    output logic             parity
);

    // Storage keeps the bare name r so parents and benches can probe <inst>.r.
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_d;
    logic             changed_q;
    logic             changed_d;

    always_comb begin
        r_d = r;
        if (clr) begin
            r_d = RESET_VAL;
        end else if (w_en) begin
            r_d = (r & ~w_mask) | (wd & w_mask);
        end
        changed_d = (r_d != r);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r         <= RESET_VAL;
            changed_q <= 1'b0;
        end else begin
            r         <= r_d;
            changed_q <= changed_d;
        end
    end

    assign rd      = r;
    assign changed = changed_q;
    assign parity  = ^r;

endmodule

// File: tb/tb_data_register.sv
// tb/tb_data_register.sv - directed vector bench for data_register
module tb_data_register;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       w_en;
    logic [1:0] w_mask;
    logic       clr;
    logic [1:0] wd;

    logic [1:0] rd_g      [2];
    logic       changed_g [2];
    logic       parity_g  [2];
    logic [1:0] rd_rv;
    logic       changed_rv;
    logic       parity_rv;
    logic [1:0] mux_rd;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_reg
        data_register #(.WIDTH(2), .RESET_VAL(2'b00)) u_reg (
            .clk     (clk),
            .rst_n   (rst_n),
            .w_en    (w_en),
            .w_mask  (w_mask),
            .clr     (clr),
            .wd      (wd),
            .rd      (rd_g[g]),
            .changed (changed_g[g]),
            .parity  (parity_g[g])
        );
    end

    data_register #(.WIDTH(2), .RESET_VAL(2'b10)) u_rv (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_en    (w_en),
        .w_mask  (w_mask),
        .clr     (clr),
        .wd      (wd),
        .rd      (rd_rv),
        .changed (changed_rv),
        .parity  (parity_rv)
    );

    assign mux_rd = w_en ? rd_g[0] : rd_g[1];

    typedef struct {
        string      name;
        logic       rst_n;
        logic       clr;
        logic       w_en;
        logic [1:0] w_mask;
        logic [1:0] wd;
        logic [1:0] exp_rd;
        logic       exp_ch;
        logic       exp_par;
        logic [1:0] exp_rv_rd;
        logic       exp_rv_ch;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic c, input logic we,
                         input logic [1:0] m, input logic [1:0] d);
        @(negedge clk);
        rst_n  = rn;
        clr    = c;
        w_en   = we;
        w_mask = m;
        wd     = d;
    endtask

    initial begin
        //           name         rst  clr  wen  mask   wd     rd     ch   par  rv_rd  rv_ch
        vecs[0]  = '{"reset_a",   1'b0,1'b0,1'b1,2'b11,2'b11, 2'b00,1'b0,1'b0,2'b10,1'b0};
        vecs[1]  = '{"reset_b",   1'b0,1'b0,1'b1,2'b11,2'b11, 2'b00,1'b0,1'b0,2'b10,1'b0};
        vecs[2]  = '{"write_01",  1'b1,1'b0,1'b1,2'b11,2'b01, 2'b01,1'b1,1'b1,2'b01,1'b1};
        vecs[3]  = '{"hold",      1'b1,1'b0,1'b0,2'b11,2'b10, 2'b01,1'b0,1'b1,2'b01,1'b0};
        vecs[4]  = '{"mask_10",   1'b1,1'b0,1'b1,2'b10,2'b10, 2'b11,1'b1,1'b0,2'b11,1'b1};
        vecs[5]  = '{"mask_00",   1'b1,1'b0,1'b1,2'b00,2'b00, 2'b11,1'b0,1'b0,2'b11,1'b0};
        vecs[6]  = '{"clr_w_en",  1'b1,1'b1,1'b1,2'b11,2'b10, 2'b00,1'b1,1'b0,2'b10,1'b1};
        vecs[7]  = '{"clr_again", 1'b1,1'b1,1'b0,2'b11,2'b01, 2'b00,1'b0,1'b0,2'b10,1'b0};
        vecs[8]  = '{"write_11",  1'b1,1'b0,1'b1,2'b11,2'b11, 2'b11,1'b1,1'b0,2'b11,1'b1};
        vecs[9]  = '{"b2b_10",    1'b1,1'b0,1'b1,2'b11,2'b10, 2'b10,1'b1,1'b1,2'b10,1'b1};
        vecs[10] = '{"same_10",   1'b1,1'b0,1'b1,2'b11,2'b10, 2'b10,1'b0,1'b1,2'b10,1'b0};
        vecs[11] = '{"rst_mid",   1'b0,1'b0,1'b1,2'b11,2'b11, 2'b00,1'b0,1'b0,2'b10,1'b0};
        vecs[12] = '{"mask_01",   1'b1,1'b0,1'b1,2'b01,2'b01, 2'b01,1'b1,1'b1,2'b11,1'b1};
        vecs[13] = '{"clr_only",  1'b1,1'b1,1'b0,2'b00,2'b00, 2'b00,1'b1,1'b0,2'b10,1'b1};

        rst_n = 1'b0; clr = 1'b0; w_en = 1'b0; w_mask = 2'b11; wd = 2'b00;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst_n, vecs[i].clr, vecs[i].w_en, vecs[i].w_mask, vecs[i].wd);
            @(posedge clk);
            #1;
            check({vecs[i].name, " rd0"},      {6'b0, rd_g[0]},            {6'b0, vecs[i].exp_rd});
            check({vecs[i].name, " changed0"}, {7'b0, changed_g[0]},       {7'b0, vecs[i].exp_ch});
            check({vecs[i].name, " parity0"},  {7'b0, parity_g[0]},        {7'b0, vecs[i].exp_par});
            check({vecs[i].name, " rd1"},      {6'b0, rd_g[1]},            {6'b0, vecs[i].exp_rd});
            check({vecs[i].name, " r0"},       {6'b0, gen_reg[0].u_reg.r}, {6'b0, vecs[i].exp_rd});
            check({vecs[i].name, " rd_rv"},    {6'b0, rd_rv},              {6'b0, vecs[i].exp_rv_rd});
            check({vecs[i].name, " changed_rv"}, {7'b0, changed_rv},       {7'b0, vecs[i].exp_rv_ch});
            check({vecs[i].name, " parity_rv"},  {7'b0, parity_rv},        {7'b0, ^vecs[i].exp_rv_rd});
        end

        // No read-during-write bypass: rd keeps the old value until the edge.
        drive(1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
        drive(1'b1, 1'b0, 1'b1, 2'b11, 2'b01);
        #1;
        check("no_bypass rd0", {6'b0, rd_g[0]}, 8'h00);
        check("no_bypass mux", {6'b0, mux_rd},  8'h00);
        @(posedge clk);
        #1;
        check("mux_sel0",  {6'b0, mux_rd},              8'h01);
        check("hier_r0",   {6'b0, gen_reg[0].u_reg.r},  {6'b0, rd_g[0]});
        check("hier_r1",   {6'b0, gen_reg[1].u_reg.r},  {6'b0, rd_g[1]});
        check("r1_val",    {6'b0, gen_reg[1].u_reg.r},  8'h01);
        check("pulse_hi",  {7'b0, changed_g[0]},        8'h01);

        // Pulse must drop after one cycle when the same value is rewritten.
        @(posedge clk);
        #1;
        check("pulse_lo",  {7'b0, changed_g[0]},        8'h00);
        check("mux_hold",  {6'b0, mux_rd},              8'h01);

        // Select instance 1 through the mux with w_en low.
        drive(1'b1, 1'b0, 1'b0, 2'b11, 2'b10);
        #1;
        check("mux_sel1",  {6'b0, mux_rd},              8'h01);
        @(posedge clk);
        #1;
        check("hold_after", {6'b0, rd_g[1]},            8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_register.md
Name: data_register

Overview:
- Parameterised, clocked storage register with write enable, per-bit write mask and synchronous clear.
- Used as a replicated leaf cell inside generate loops. Each instance holds one small field (default 2 bits) of a wider register bank.
- The parent selects between instances by reading each instance's output.
- Storage is a single flop vector named `r`. `r` must remain hierarchically visible as `<instance>.r` for debug and bench probing.

Parameters:
- WIDTH, 2, data width in bits (legal range 1..64).
- RESET_VAL, 0 (WIDTH bits), value loaded into `r` by reset and by `clr`.

Ports:
- clk      input   1      single clock; all state updates on its rising edge.
- rst_n    input   1      synchronous reset, active-low.
- w_en     input   1      write enable.
- w_mask   input   WIDTH  per-bit write mask; 1 = bit is writable. Tie all-ones for plain writes.
- clr      input   1      synchronous clear to RESET_VAL.
- wd       input   WIDTH  write data.
- rd       output  WIDTH  read data, equal to `r`.
- changed  output  1      one-cycle pulse: `r` changed value on the previous edge.
- parity   output  1      even parity of `r` (XOR of all bits).

Behaviour:
- All sequential logic is evaluated on the rising edge of clk only. No asynchronous paths exist.
- Reset, rst_n=0 at an edge:
  - r <= RESET_VAL; changed <= 0.
  - Overrides clr and w_en.
  - Reset asserted mid-operation discards any write in that cycle.
- Priority when rst_n=1: clr first, then w_en, then hold.
- clr=1: r <= RESET_VAL regardless of w_en, w_mask and wd.
- w_en=1 and clr=0: r <= (r & ~w_mask) | (wd & w_mask).
  - Bits with w_mask=0 keep their value.
  - w_mask all-zero makes the write a no-op.
- w_en=0 and clr=0: r holds its value.
- rd:
  - Purely combinational copy of `r`; no extra read latency.
  - A write at edge N is visible on rd immediately after edge N.
  - There is no read-during-write bypass: before edge N, rd shows the old value.
- changed:
  - Registered. Goes high for exactly one cycle after any edge where the new `r` differs from the old `r`, whether by clr or write.
  - A write of an identical value, or a clr while already at RESET_VAL, gives changed=0.
  - Back-to-back differing writes hold changed high on consecutive cycles.
- parity = XOR-reduce(r), combinational.
- Before the first reset, `r` is X. The block has no internal initialisation; the parent must apply reset.
- Data path must be width-generic: no hard-coded bit indices. WIDTH=1 must synthesise.

Test Plan (WIDTH=2, RESET_VAL=0 unless stated):
- Reset: hold rst_n=0 for 2 edges with w_en=1, wd=2'b11 -> rd=2'b00, changed=0, parity=0. Then release rst_n.
- Basic write: w_en=1, w_mask=2'b11, wd=2'b01 at one edge -> rd=2'b01 right after that edge, changed=1 for one cycle, parity=1. Next cycle with w_en=0 -> rd stays 2'b01, changed=0.
- Masked write: r=2'b01, then w_en=1, w_mask=2'b10, wd=2'b10 -> rd=2'b11. Then w_mask=2'b00, wd=2'b00 -> rd stays 2'b11, changed=0.
- Clear priority: r=2'b11, clr=1 and w_en=1, wd=2'b10 together -> rd=2'b00, changed=1. Repeat clr -> changed=0. Rerun with RESET_VAL=2'b10 -> rd=2'b10.
- Reset mid-write: rst_n=0 on the same edge as w_en=1, wd=2'b11 -> rd=2'b00. Write resumes normally after rst_n=1.
- Two instances in a generate loop, both fed wd=2'b01, w_en=1: after one edge, a mux selecting instance 0's rd when w_en=1, else instance 1's rd, outputs 2'b01. Hierarchical `<instance>.r` equals rd for both instances.
